// File: rtl/fifo_axis_reader.sv
// fifo_axis_reader: drains an async_fifo read port (show-ahead) into an
// AXI4-Stream master. A two-entry buffer (head + skid) keeps rd_en free of
// any dependence on tready while still sustaining one beat per clock.
// tlast is raised on every BEATS-th accepted beat.
module fifo_axis_reader #(
  parameter int W     = 8,
  parameter int BEATS = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rd_empty,
  input  logic [W-1:0] rd_data,
  output logic         rd_en,
  output logic         tvalid,
  output logic [W-1:0] tdata,
  output logic         tlast,
  input  logic         tready,
  output logic [1:0]   buf_count
);

  localparam int            CW        = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  // Occupancy doubles as the FSM state; encodings equal the word count.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  head_q, skid_q;
  logic [CW-1:0] beat_cnt;
  logic          push, pop;
  logic          head_from_rd, head_from_skid, skid_load;

  // Pop decision looks only at registered state and rd_empty, never tready,
  // so the FIFO is never popped while empty and no tready->rd_en path exists.
  assign rd_en     = ~reset & ~rd_empty & (state_q != S_FULL);
  assign push      = rd_en;
  assign pop       = tvalid & tready;
  assign tvalid    = (state_q != S_EMPTY);
  assign tdata     = head_q;
  assign buf_count = state_q;
  assign tlast     = tvalid & (beat_cnt == LAST_BEAT);

  // Next occupancy and which buffer entry to load this cycle.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case leaves a signal unassigned and infers a latch.
    state_d        = state_q;
    head_from_rd   = 1'b0;
    head_from_skid = 1'b0;
    skid_load      = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (push) begin
          head_from_rd = 1'b1;
          state_d      = S_ONE;
        end
      end
      S_ONE: begin
        if (push && pop) begin
          head_from_rd = 1'b1;
        end else if (push) begin
          skid_load = 1'b1;
          state_d   = S_FULL;
        end else if (pop) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        if (pop) begin
          head_from_skid = 1'b1;
          state_d        = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // Occupancy state register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (reset) state_q <= S_EMPTY;
    else       state_q <= state_d;
  end

  // Buffer entries: head feeds tdata, skid catches the second word.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: these data registers are reset on purpose so a flushed buffer
    // reads as zero; plain datapath storage would normally skip the reset.
    if (reset) begin
      head_q <= '0;
      skid_q <= '0;
    end else begin
      if (head_from_rd)        head_q <= rd_data;
      else if (head_from_skid) head_q <= skid_q;
      if (skid_load)           skid_q <= rd_data;
    end
  end

  // Beat counter: advances on each accepted beat, wraps after BEATS-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_cnt <= '0;
    end else if (pop) begin
      beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_fifo_axis_reader.sv
// Bench for fifo_axis_reader: a queue-based FIFO model feeds four instances
// (BEATS = 4, 1, 8, 16) with identical stimulus. Pop behaviour does not
// depend on BEATS, so one model serves all of them; only tlast differs.
// Stimulus pushes expected words into exp_q; a monitor pops and compares.
module tb_fifo_axis_reader;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset    = 1'b1;
  logic         rd_empty = 1'b1;
  logic [W-1:0] rd_data  = '0;
  logic         tready   = 1'b0;

  // Main instance, BEATS = 4.
  logic         rd_en, tvalid, tlast;
  logic [W-1:0] tdata;
  logic [1:0]   buf_count;

  // Extra instances: index 0 -> BEATS=1, 1 -> BEATS=8, 2 -> BEATS=16.
  logic [2:0]   x_rd_en, x_tvalid, x_tlast;
  logic [W-1:0] x_tdata [3];
  logic [1:0]   x_bc    [3];

  fifo_axis_reader #(.W(W), .BEATS(4)) dut (
    .clk(clk), .reset(reset), .rd_empty(rd_empty), .rd_data(rd_data),
    .rd_en(rd_en), .tvalid(tvalid), .tdata(tdata), .tlast(tlast),
    .tready(tready), .buf_count(buf_count)
  );
  fifo_axis_reader #(.W(W), .BEATS(1)) dut_b1 (
    .clk(clk), .reset(reset), .rd_empty(rd_empty), .rd_data(rd_data),
    .rd_en(x_rd_en[0]), .tvalid(x_tvalid[0]), .tdata(x_tdata[0]), .tlast(x_tlast[0]),
    .tready(tready), .buf_count(x_bc[0])
  );
  fifo_axis_reader #(.W(W), .BEATS(8)) dut_b8 (
    .clk(clk), .reset(reset), .rd_empty(rd_empty), .rd_data(rd_data),
    .rd_en(x_rd_en[1]), .tvalid(x_tvalid[1]), .tdata(x_tdata[1]), .tlast(x_tlast[1]),
    .tready(tready), .buf_count(x_bc[1])
  );
  fifo_axis_reader #(.W(W), .BEATS(16)) dut_b16 (
    .clk(clk), .reset(reset), .rd_empty(rd_empty), .rd_data(rd_data),
    .rd_en(x_rd_en[2]), .tvalid(x_tvalid[2]), .tdata(x_tdata[2]), .tlast(x_tlast[2]),
    .tready(tready), .buf_count(x_bc[2])
  );

  int checks = 0;
  int errors = 0;

  logic [W-1:0] fifo_q [$];  // words sitting in the modelled async_fifo
  logic [W-1:0] exp_q  [$];  // words still owed on the stream, in order
  int           in_buf = 0;  // words popped from FIFO but not yet accepted
  int           pops   = 0;  // total FIFO pops seen
  int           beat_n = 0;  // accepted beats since last reset

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [W-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while ((exp_q.size() != 0 || in_buf != 0) && n < max_cycles) begin
      tick();
      n++;
    end
    check("drain_words_left", exp_q.size(), 0);
  endtask

  // FIFO model, read side: head word becomes visible at the falling edge.
  always @(negedge clk) begin
    rd_empty = (fifo_q.size() == 0);
    rd_data  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  end

  // FIFO model, pop side, plus bookkeeping of words held inside the DUT.
  always @(posedge clk) begin
    if (reset) begin
      // Buffered words are discarded by reset; they never reach the stream.
      repeat (in_buf) if (exp_q.size() != 0) void'(exp_q.pop_front());
      in_buf = 0;
    end else begin
      if (rd_en && fifo_q.size() != 0) begin
        void'(fifo_q.pop_front());
        pops++;
      end
      in_buf = in_buf + int'(rd_en) - int'(tvalid & tready);
    end
  end

  // Monitor: samples late in the cycle, compares against exp_q.
  initial begin : monitor
    logic         hold = 1'b0;
    logic [W-1:0] hold_data = '0;
    logic         hold_last = 1'b0;
    logic [W-1:0] w;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        beat_n = 0;
        hold   = 1'b0;
      end else begin
        check("rd_en_while_empty", rd_en & rd_empty, 0);
        check("buf_count", buf_count, in_buf);
        check("tvalid", tvalid, in_buf != 0);
        for (int i = 0; i < 3; i++) begin
          check("x_buf_count", x_bc[i], in_buf);
          check("x_tvalid", x_tvalid[i], in_buf != 0);
          check("x_rd_en", x_rd_en[i], !rd_empty && in_buf != 2);
        end
        if (hold) begin
          check("hold_tvalid", tvalid, 1);
          check("hold_tdata", tdata, hold_data);
          check("hold_tlast", tlast, hold_last);
        end
        if (tvalid) begin
          check("beat_owed", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            w = exp_q[0];
            check("tdata", tdata, w);
            for (int i = 0; i < 3; i++) check("x_tdata", x_tdata[i], w);
            check("tlast_b4", tlast, (beat_n % 4) == 3);
            check("tlast_b1", x_tlast[0], 1);
            check("tlast_b8", x_tlast[1], (beat_n % 8) == 7);
            check("tlast_b16", x_tlast[2], (beat_n % 16) == 15);
          end
          if (tready) begin
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            beat_n++;
            hold = 1'b0;
          end else begin
            hold      = 1'b1;
            hold_data = tdata;
            hold_last = tlast;
          end
        end else begin
          check("tlast_idle", {tlast, x_tlast}, 0);
          hold = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed scenarios.
  initial begin : stimulus
    int n;
    int p0;

    // Reset state.
    reset = 1'b1;
    tick();
    tick();
    check("rst_tvalid", tvalid, 0);
    check("rst_tlast", tlast, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_buf_count", buf_count, 0);
    reset = 1'b0;

    // Single word 0xA5 with tready high: one beat, buf_count 0->1->0.
    tready = 1'b1;
    tick();
    write_word(8'hA5);
    check("single_bc0", buf_count, 0);
    @(negedge clk);
    #1;
    check("single_rd_en", rd_en, 1);
    tick();
    check("single_tvalid", tvalid, 1);
    check("single_tdata", tdata, 8'hA5);
    check("single_tlast", tlast, 0);
    check("single_bc1", buf_count, 1);
    tick();
    check("single_tvalid_off", tvalid, 0);
    check("single_bc_back", buf_count, 0);
    n = 0;
    repeat (4) begin
      tick();
      if (tvalid) n++;
    end
    check("single_no_repeat", n, 0);

    // Streaming 0x00..0x0B: 12 back-to-back beats, tlast on 03/07/0B.
    do_reset();
    tready = 1'b1;
    for (int i = 0; i < 12; i++) write_word(W'(i));
    n = 0;
    while (!tvalid && n < 10) begin
      tick();
      n++;
    end
    check("stream_start", tvalid, 1);
    n = 0;
    while (tvalid && tready && n < 20) begin
      n++;
      tick();
    end
    check("stream_gapless_beats", n, 12);
    drain(20);

    // Backpressure: 5 words, tready low -> exactly 2 pops, buffer full.
    do_reset();
    tready = 1'b0;
    p0 = pops;
    for (int i = 0; i < 5; i++) write_word(8'h10 + W'(i));
    repeat (8) tick();
    check("bp_pops", pops - p0, 2);
    check("bp_buf_count", buf_count, 2);
    check("bp_rd_en", rd_en, 0);
    check("bp_rd_empty", rd_empty, 0);
    check("bp_tdata", tdata, 8'h10);
    tready = 1'b1;
    drain(30);
    check("bp_total_pops", pops - p0, 5);

    // BEATS=1 instance: 3 words, tlast on every beat (checked by monitor).
    do_reset();
    for (int i = 0; i < 3; i++) write_word(8'hC0 + W'(i));
    drain(20);

    // Reset mid-packet: 6 beats accepted, buffer full, then reset.
    do_reset();
    tready = 1'b1;
    for (int i = 0; i < 6; i++) write_word(8'h20 + W'(i));
    drain(20);
    check("mid_beats_before", beat_n, 6);
    tready = 1'b0;
    for (int i = 0; i < 4; i++) write_word(8'h26 + W'(i));
    repeat (5) tick();
    check("mid_bc_full", buf_count, 2);
    reset = 1'b1;
    #1;
    check("mid_rst_tvalid", tvalid, 0);
    check("mid_rst_tlast_b8", x_tlast[1], 0);
    check("mid_rst_rd_en", rd_en, 0);
    check("mid_rst_bc", buf_count, 0);
    tick();
    tick();
    reset = 1'b0;
    // 0x28, 0x29 remain in the FIFO; 8 more give 10 post-reset beats,
    // so the BEATS=8 instance must mark 0x2F (8th beat).
    tready = 1'b1;
    for (int i = 0; i < 8; i++) write_word(8'h2A + W'(i));
    drain(30);
    check("mid_beats_after", beat_n, 10);

    // Random tready and FIFO writes, 1000 words.
    do_reset();
    n = 0;
    while (n < 1000) begin
      tready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        write_word(W'($urandom));
        n++;
      end
      tick();
    end
    tready = 1'b1;
    drain(200);
    check("rand_beats", beat_n, 1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
